// File: rtl/x1_vram_cpu_port.sv
// rtl/x1_vram_cpu_port.sv - CPU access port onto the shared VRAM/GRAM bus, slotted against video fetch
module x1_vram_cpu_port (
  input  logic        I_VCLK,
  input  logic        I_RESET,
  input  logic [15:0] I_A,
  input  logic [7:0]  I_D,
  input  logic        I_WR,
  input  logic        I_RD,
  input  logic        I_TXT_CS,
  input  logic        I_ATT_CS,
  input  logic        I_KAN_CS,
  input  logic        I_GRB_CS,
  input  logic        I_GRR_CS,
  input  logic        I_GRG_CS,
  input  logic        I_SLOT,
  input  logic [7:0]  I_TXT_D,
  input  logic [7:0]  I_ATT_D,
  input  logic [7:0]  I_KAN_D,
  input  logic [7:0]  I_GRB_D,
  input  logic [7:0]  I_GRR_D,
  input  logic [7:0]  I_GRG_D,
  output logic [13:0] O_VA,
  output logic        O_VA_SEL,
  output logic        O_TXT_WE,
  output logic        O_ATT_WE,
  output logic        O_KAN_WE,
  output logic        O_GRB_WE,
  output logic        O_GRR_WE,
  output logic        O_GRG_WE,
  output logic [7:0]  O_WD,
  output logic [7:0]  O_D,
  output logic        O_DE,
  output logic        O_VWAIT,
  output logic        O_BUSY
);

  typedef enum logic [2:0] {IDLE, PEND, ACC0, ACC1, DONE} state_t;

  // Select vector order: {TXT, ATT, KAN, GRB, GRR, GRG}; bit 5 has highest read priority.
  logic [5:0]  cs_in;
  logic        req;
  logic        unused_addr_hi;

  state_t      state_q, state_d;
  logic        req_s1_q, req_s1_d;
  logic        req_s_q, req_s_d;
  logic [7:0]  data_q, data_d;
  logic        wr_q, wr_d;
  logic [5:0]  cs_q, cs_d;
  logic [13:0] va_q, va_d;
  logic [7:0]  rd_q, rd_d;
  logic        ack_q, ack_d;
  logic [5:0]  we;

  assign cs_in          = {I_TXT_CS, I_ATT_CS, I_KAN_CS, I_GRB_CS, I_GRR_CS, I_GRG_CS};
  assign req            = (|cs_in) & (I_WR | I_RD);
  assign unused_addr_hi = &{1'b0, I_A[15:14]};

  // State and captured request registers; reset aborts any access in flight.
  always_ff @(posedge I_VCLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q  <= IDLE;
      req_s1_q <= 1'b0;
      req_s_q  <= 1'b0;
      data_q   <= 8'h00;
      wr_q     <= 1'b0;
      cs_q     <= 6'b0;
      va_q     <= 14'h0000;
      rd_q     <= 8'h00;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_s1_q <= req_s1_d;
      req_s_q  <= req_s_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      cs_q     <= cs_d;
      va_q     <= va_d;
      rd_q     <= rd_d;
      ack_q    <= ack_d;
    end
  end

  // Next state, request capture, slot handshake and read-data latch.
  always_comb begin
    state_d  = state_q;
    req_s1_d = req;
    req_s_d  = req_s1_q;
    data_d   = data_q;
    wr_d     = wr_q;
    cs_d     = cs_q;
    va_d     = va_q;
    rd_d     = rd_q;
    ack_d    = ack_q;
    case (state_q)
      IDLE: begin
        if (req_s_q) begin
          state_d = PEND;
          data_d  = I_D;
          wr_d    = I_WR;
          cs_d    = cs_in;
          // Graphic planes use the full 14-bit address; text planes are 2K deep.
          if (|cs_in[2:0])      va_d = I_A[13:0];
          else if (|cs_in[5:3]) va_d = {3'b000, I_A[10:0]};
        end
      end
      PEND: begin
        if (I_SLOT) state_d = ACC0;
      end
      ACC0: begin
        // Losing the slot before the second cycle abandons this attempt without a write.
        state_d = I_SLOT ? ACC1 : PEND;
      end
      ACC1: begin
        state_d = DONE;
        ack_d   = 1'b1;
        if (!wr_q) begin
          if (cs_q[5])      rd_d = I_TXT_D;
          else if (cs_q[4]) rd_d = I_ATT_D;
          else if (cs_q[3]) rd_d = I_KAN_D;
          else if (cs_q[2]) rd_d = I_GRB_D;
          else if (cs_q[1]) rd_d = I_GRR_D;
          else if (cs_q[0]) rd_d = I_GRG_D;
        end
      end
      DONE: begin
        // Hold here until the CPU drops its strobe so one strobe gives one access.
        if (!req_s_q) begin
          state_d = IDLE;
          ack_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign we = (state_q == ACC1 && wr_q) ? cs_q : 6'b0;

  assign {O_TXT_WE, O_ATT_WE, O_KAN_WE, O_GRB_WE, O_GRR_WE, O_GRG_WE} = we;
  assign O_VA     = va_q;
  assign O_VA_SEL = (state_q == ACC0) || (state_q == ACC1);
  assign O_WD     = (state_q != IDLE) ? data_q : 8'h00;
  assign O_D      = rd_q;
  assign O_DE     = (state_q == DONE) && !wr_q;
  assign O_BUSY   = (state_q != IDLE);
  // Wait is combinational from the raw request so the CPU is stalled in the very cycle it asks.
  assign O_VWAIT  = req & ~ack_q & ~I_RESET;

endmodule
